// File: rtl/fft_pkg.sv
// Shared types and address arithmetic for the radix-2 DIT FFT stage sequencer.
package fft_pkg;

  localparam int N_LOG2_DEFAULT = 4;
  localparam int ADDR_MAX_W     = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] a;
    logic [ADDR_MAX_W-1:0] b;
    logic [ADDR_MAX_W-1:0] tw;
  } addr_t;

  // Butterfly j of stage s pairs a and a+2^s; twiddle step shrinks as stages widen.
  function automatic addr_t addr_gen(input int unsigned n_log2,
                                     input int unsigned s,
                                     input int unsigned j);
    int unsigned half;
    int unsigned pos;
    int unsigned a;
    addr_t       r;
    half = 32'd1 << s;
    pos  = j & (half - 32'd1);
    a    = ((j >> s) << (s + 32'd1)) | pos;
    r.a  = ADDR_MAX_W'(a);
    r.b  = ADDR_MAX_W'(a + half);
    r.tw = ADDR_MAX_W'(pos << (n_log2 - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register chain with asynchronous active-low clear.
module fft_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: read/twiddle issue, drain gaps, delayed write-back.
// Optional inverse-transform control is enabled by defining FFT_STAGE_CTRL_INVERSE_EN.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2   = N_LOG2_DEFAULT,
  parameter int PIPE_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
`ifdef FFT_STAGE_CTRL_INVERSE_EN
  input  logic              i_inverse,
  output logic              o_tw_conj,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [N_LOG2-1:0] o_stage,
  output logic              o_rd_en,
  output logic [N_LOG2-1:0] o_rd_addr_a,
  output logic [N_LOG2-1:0] o_rd_addr_b,
  output logic [N_LOG2-2:0] o_tw_idx,
  output logic              o_wr_en,
  output logic [N_LOG2-1:0] o_wr_addr_a,
  output logic [N_LOG2-1:0] o_wr_addr_b
);

  localparam int J_W     = N_LOG2 - 1;
  localparam int CNT_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int LINE_W  = 1 + 2 * N_LOG2;

  localparam logic [J_W-1:0]    LAST_J   = {J_W{1'b1}};
  localparam logic [N_LOG2-1:0] LAST_S   = N_LOG2'(N_LOG2 - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PIPE_LAT - 1);

  state_t            state;
  logic [N_LOG2-1:0] s;
  logic [J_W-1:0]    j;
  logic [CNT_W-1:0]  drain_cnt;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic              tw_conj;

  // The drain gap lets every write of a stage land before the next stage reads.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      s         <= '0;
      j         <= '0;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tw_conj   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= ISSUE;
            s     <= '0;
            j     <= '0;
            rd_en <= 1'b1;
            busy  <= 1'b1;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
            tw_conj <= i_inverse;
`else
            tw_conj <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (j == LAST_J) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else begin
            j <= j + J_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_CNT) begin
            if (s != LAST_S) begin
              state <= ISSUE;
              s     <= s + N_LOG2'(1);
              j     <= '0;
              rd_en <= 1'b1;
            end else begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              tw_conj <= 1'b0;
            end
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          s     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  addr_t gen;
  logic  unused_gen_bits;

  always_comb begin
    gen = addr_gen(N_LOG2, 32'(s), 32'(j));
  end

  assign unused_gen_bits = ^{gen.a[ADDR_MAX_W-1:N_LOG2], gen.b[ADDR_MAX_W-1:N_LOG2],
                             gen.tw[ADDR_MAX_W-1:N_LOG2-1]};

  // Addresses are forced to zero outside read cycles so idle outputs stay quiet.
  assign o_rd_en     = rd_en;
  assign o_rd_addr_a = rd_en ? gen.a[N_LOG2-1:0]  : '0;
  assign o_rd_addr_b = rd_en ? gen.b[N_LOG2-1:0]  : '0;
  assign o_tw_idx    = rd_en ? gen.tw[N_LOG2-2:0] : '0;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_stage     = s;

`ifdef FFT_STAGE_CTRL_INVERSE_EN
  assign o_tw_conj = tw_conj;
`else
  logic unused_tw_conj;
  assign unused_tw_conj = tw_conj;
`endif

  fft_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (LINE_W)
  ) u_wr_delay (
    .clk   (i_clk),
    .rst_n (i_reset),
    .d     ({o_rd_en, o_rd_addr_a, o_rd_addr_b}),
    .q     ({o_wr_en, o_wr_addr_a, o_wr_addr_b})
  );

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: directed scenarios plus random starts/resets against a trace model.
module tb_fft_stage_ctrl;

  localparam int N_LOG2      = 3;
  localparam int PIPE_LAT    = 2;
  localparam int N           = 1 << N_LOG2;
  localparam int HALF_N      = N / 2;
  localparam int PERIOD      = HALF_N + PIPE_LAT;
  localparam int BUSY_CYCLES = N_LOG2 * PERIOD;

  typedef struct {
    bit en;
    int a;
    int b;
    int tw;
  } pair_t;

  logic              i_clk   = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_start = 1'b0;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
  logic              i_inverse = 1'b0;
  logic              o_tw_conj;
`endif
  logic              o_busy;
  logic              o_done;
  logic [N_LOG2-1:0] o_stage;
  logic              o_rd_en;
  logic [N_LOG2-1:0] o_rd_addr_a;
  logic [N_LOG2-1:0] o_rd_addr_b;
  logic [N_LOG2-2:0] o_tw_idx;
  logic              o_wr_en;
  logic [N_LOG2-1:0] o_wr_addr_a;
  logic [N_LOG2-1:0] o_wr_addr_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  fft_stage_ctrl #(
    .N_LOG2   (N_LOG2),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    .i_inverse   (i_inverse),
    .o_tw_conj   (o_tw_conj),
`endif
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_stage     (o_stage),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .o_tw_idx    (o_tw_idx),
    .o_wr_en     (o_wr_en),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit start);
    i_start = start;
  endtask

  task automatic toCycle(input int c);
    while (cyc < c) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Butterfly r of stage s: groups of 2*half samples, twiddle stride N/(2*half).
  function automatic pair_t model_read(input int t);
    pair_t p;
    int k, st, r, half, grp, pos;
    p = '{0, 0, 0, 0};
    if (t >= 1 && t <= BUSY_CYCLES) begin
      k  = t - 1;
      st = k / PERIOD;
      r  = k % PERIOD;
      if (r < HALF_N) begin
        half = 2 ** st;
        grp  = r / half;
        pos  = r % half;
        p.en = 1;
        p.a  = grp * 2 * half + pos;
        p.b  = p.a + half;
        p.tw = pos * (N / (2 * half));
      end
    end
    return p;
  endfunction

  bit    m_active = 0;
  int    m_start  = 0;
  bit    m_inv    = 0;
  int    t_rel;
  bit    exp_busy;
  bit    exp_done;
  pair_t exp_rd;
  pair_t exp_wr;
  pair_t wq[$];

  task automatic model_reset();
    m_active = 0;
    m_inv    = 0;
    wq.delete();
    for (int i = 0; i < PIPE_LAT; i++) wq.push_back('{0, 0, 0, 0});
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_rd_en", o_rd_en, 0);
        checkOutput("reset_wr_en", o_wr_en, 0);
        model_reset();
      end else begin
        t_rel    = m_active ? cyc - m_start : 0;
        exp_rd   = m_active ? model_read(t_rel) : '{0, 0, 0, 0};
        exp_busy = m_active && t_rel >= 1 && t_rel <= BUSY_CYCLES;
        exp_done = m_active && t_rel == BUSY_CYCLES + 1;
        exp_wr   = wq.pop_front();
        wq.push_back(exp_rd);
        checkOutput("busy", o_busy, exp_busy);
        checkOutput("done", o_done, exp_done);
        checkOutput("rd_en", o_rd_en, exp_rd.en);
        if (exp_rd.en) begin
          checkOutput("rd_addr_a", o_rd_addr_a, exp_rd.a);
          checkOutput("rd_addr_b", o_rd_addr_b, exp_rd.b);
          checkOutput("tw_idx", o_tw_idx, exp_rd.tw);
        end
        if (exp_busy) checkOutput("stage", o_stage, (t_rel - 1) / PERIOD);
        checkOutput("wr_en", o_wr_en, exp_wr.en);
        if (exp_wr.en) begin
          checkOutput("wr_addr_a", o_wr_addr_a, exp_wr.a);
          checkOutput("wr_addr_b", o_wr_addr_b, exp_wr.b);
        end
`ifdef FFT_STAGE_CTRL_INVERSE_EN
        checkOutput("tw_conj", o_tw_conj, exp_busy ? m_inv : 0);
`endif
        if ((!m_active || t_rel > BUSY_CYCLES + 1) && i_start) begin
          m_active = 1;
          m_start  = cyc;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
          m_inv = i_inverse;
`endif
        end
      end
    end
  end

  // Literal pins of the first scenario's trace, relative to the start cycle b.
  task automatic runBasic(input int b);
    toCycle(b);
    applyStimulus(1);
    toCycle(b + 1);
    applyStimulus(0);
    checkOutput("lit_busy_c1", o_busy, 1);
    checkOutput("lit_rd_a_c1", o_rd_addr_a, 0);
    checkOutput("lit_rd_b_c1", o_rd_addr_b, 1);
    toCycle(b + 6);
    checkOutput("lit_rd_en_c6", o_rd_en, 0);
    checkOutput("lit_wr_en_c6", o_wr_en, 1);
    checkOutput("lit_wr_a_c6", o_wr_addr_a, 6);
    checkOutput("lit_wr_b_c6", o_wr_addr_b, 7);
    toCycle(b + 8);
    checkOutput("lit_rd_a_c8", o_rd_addr_a, 1);
    checkOutput("lit_rd_b_c8", o_rd_addr_b, 3);
    checkOutput("lit_tw_c8", o_tw_idx, 2);
    toCycle(b + 16);
    checkOutput("lit_rd_b_c16", o_rd_addr_b, 7);
    checkOutput("lit_tw_c16", o_tw_idx, 3);
    toCycle(b + 18);
    checkOutput("lit_wr_a_c18", o_wr_addr_a, 3);
    checkOutput("lit_busy_c18", o_busy, 1);
    toCycle(b + 19);
    checkOutput("lit_done_c19", o_done, 1);
    checkOutput("lit_busy_c19", o_busy, 0);
    toCycle(b + 20);
    checkOutput("lit_done_c20", o_done, 0);
    checkOutput("lit_busy_c20", o_busy, 0);
  endtask

  int b;
  int rst_hold = 0;

  initial begin
    #2;
    checkOutput("init_rd_en", o_rd_en, 0);
    checkOutput("init_busy", o_busy, 0);
    toCycle(3);
    i_reset = 1'b1;

    $display("[TB] basic transform");
    runBasic(cyc + 2);

    $display("[TB] start pulse while busy");
    b = cyc + 2;
    toCycle(b);
    applyStimulus(1);
    toCycle(b + 1);
    applyStimulus(0);
    toCycle(b + 3);
    applyStimulus(1);
    toCycle(b + 4);
    applyStimulus(0);
    toCycle(b + 19);
    checkOutput("busy_pulse_done", o_done, 1);
    toCycle(b + 21);
    checkOutput("busy_pulse_idle", o_busy, 0);

    $display("[TB] reset mid-run");
    b = cyc + 2;
    toCycle(b);
    applyStimulus(1);
    toCycle(b + 1);
    applyStimulus(0);
    toCycle(b + 9);
    i_reset = 1'b0;
    #1;
    checkOutput("midrst_rd_en", o_rd_en, 0);
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_wr_en", o_wr_en, 0);
    checkOutput("midrst_rd_a", o_rd_addr_a, 0);
    checkOutput("midrst_stage", o_stage, 0);
    toCycle(b + 11);
    i_reset = 1'b1;
    toCycle(b + 16);
    runBasic(cyc + 2);

    $display("[TB] start held through done");
    b = cyc + 2;
    toCycle(b);
    applyStimulus(1);
    toCycle(b + 20);
    checkOutput("held_busy_c20", o_busy, 0);
    toCycle(b + 21);
    applyStimulus(0);
    checkOutput("held_busy_c21", o_busy, 1);
    checkOutput("held_rd_b_c21", o_rd_addr_b, 1);
    toCycle(b + 42);

`ifdef FFT_STAGE_CTRL_INVERSE_EN
    $display("[TB] inverse transform");
    b = cyc + 2;
    toCycle(b);
    applyStimulus(1);
    i_inverse = 1'b1;
    toCycle(b + 1);
    applyStimulus(0);
    i_inverse = 1'b0;
    checkOutput("inv_conj_c1", o_tw_conj, 1);
    toCycle(b + 18);
    checkOutput("inv_conj_c18", o_tw_conj, 1);
    toCycle(b + 19);
    checkOutput("inv_conj_c19", o_tw_conj, 0);
    toCycle(b + 22);
`endif

    $display("[TB] random starts and resets");
    for (int i = 0; i < 700; i++) begin
      @(posedge i_clk);
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) i_reset = 1'b1;
        applyStimulus(0);
      end else if ($urandom_range(0, 249) == 0) begin
        i_reset  = 1'b0;
        rst_hold = $urandom_range(1, 3);
        applyStimulus(0);
      end else begin
        applyStimulus($urandom_range(0, 5) == 0);
`ifdef FFT_STAGE_CTRL_INVERSE_EN
        i_inverse = 1'($urandom_range(0, 1));
`endif
      end
    end
    i_reset = 1'b1;
    applyStimulus(0);
    toCycle(cyc + 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
